// File: rtl/spi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_slave
// Description : Memory stage behind the SPI slave. It decodes each 10-bit
//               frame as {command[1:0], payload[7:0]} and performs
//               write-address latching, memory writes, read-address latching
//               and memory reads. Read bytes go back to the SPI slave for
//               shifting out on MISO. It also raises a sticky flag when read
//               data is requested without a preceding read address.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   rx_data_i    in  10  frame from SPI slave: [9:8] command, [7:0] payload
//   rx_valid_i   in   1  one-cycle strobe qualifying rx_data_i
//   err_clr_i    in   1  synchronous clear of proto_err_o
//   tx_data_o    out  8  read byte returned to SPI slave
//   tx_valid_o   out  1  tx_data_o valid (level, held until next command)
//   rd_pending_o out  1  read address latched, read-data not yet consumed
//   proto_err_o  out  1  sticky protocol-error flag
// ============================================================================
module spi_ram_slave #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 err_clr_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    output logic                 rd_pending_o,
    output logic                 proto_err_o
);

    localparam logic [1:0] C_CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] C_CMD_WR_DATA = 2'b01;
    localparam logic [1:0] C_CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] C_CMD_RD_DATA = 2'b11;

    // Storage array; intentionally left without a reset.
    logic [7:0]           mem_q [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_addr_q,    wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q,    rd_addr_d;
    logic [7:0]           tx_data_q,    tx_data_d;
    logic                 tx_valid_q,   tx_valid_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 proto_err_q,  proto_err_d;

    logic [1:0]           w_cmd;
    logic [7:0]           w_payload;
    logic                 w_mem_we;

    assign w_cmd     = rx_data_i[9:8];
    assign w_payload = rx_data_i[7:0];

    // Writes are suppressed while reset is held so traffic seen during reset
    // cannot disturb memory contents.
    assign w_mem_we  = rx_valid_i && rst_n && (w_cmd == C_CMD_WR_DATA);

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    always_comb begin
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        rd_pending_d = rd_pending_q;
        proto_err_d  = proto_err_q;

        // Clear is evaluated first so that a same-cycle set below overrides it.
        if (err_clr_i) begin
            proto_err_d = 1'b0;
        end

        if (rx_valid_i) begin
            case (w_cmd)
                C_CMD_WR_ADDR: begin
                    wr_addr_d  = w_payload[ADDR_SIZE-1:0];
                    tx_valid_d = 1'b0;
                end
                C_CMD_WR_DATA: begin
                    tx_valid_d = 1'b0;
                end
                C_CMD_RD_ADDR: begin
                    // Re-latching while a read is pending simply replaces it.
                    rd_addr_d    = w_payload[ADDR_SIZE-1:0];
                    rd_pending_d = 1'b1;
                    tx_valid_d   = 1'b0;
                end
                default: begin
                    // Read data: the memory is written on the clock edge, so a
                    // write in the previous cycle is already visible here.
                    tx_data_d    = mem_q[rd_addr_q];
                    tx_valid_d   = 1'b1;
                    rd_pending_d = 1'b0;
                    if (!rd_pending_q) begin
                        proto_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rd_pending_q <= rd_pending_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_addr_q] <= w_payload;
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign rd_pending_o = rd_pending_q;
    assign proto_err_o  = proto_err_q;

endmodule
`default_nettype wire
